// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution unit.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BLE  = 3'd3,
    FBLT = 3'd4,
    FBLE = 3'd5,
    FBPS = 3'd6,
    FBNG = 3'd7
  } funct_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_INIT = 2'b01;
  localparam int       PC_STEP  = 4;

  // Saturating increment of a 2-bit history counter.
  function automatic bht_ctr_t sat_inc(input bht_ctr_t ctr);
    return (ctr == 2'b11) ? ctr : ctr + 2'b01;
  endfunction

  // Saturating decrement of a 2-bit history counter.
  function automatic bht_ctr_t sat_dec(input bht_ctr_t ctr);
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation for integer and sign-magnitude float compares.
module branch_cond
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  funct_e          funct,
  input  logic [XLEN-1:0] read1,
  input  logic [XLEN-1:0] read2,
  output logic            taken
);

  logic            sign1;
  logic            sign2;
  logic [XLEN-2:0] mag1;
  logic [XLEN-2:0] mag2;
  logic            eq;
  logic            flt;

  assign sign1 = read1[XLEN-1];
  assign sign2 = read2[XLEN-1];
  assign mag1  = read1[XLEN-2:0];
  assign mag2  = read2[XLEN-2:0];
  assign eq    = (read1 == read2);

  // Float less-than on raw sign/magnitude: -0 < +0 holds and NaN is not special.
  always_comb begin
    flt = 1'b0;
    unique case ({sign1, sign2})
      2'b00:   flt = (mag1 < mag2);
      2'b01:   flt = 1'b0;
      2'b10:   flt = 1'b1;
      default: flt = (mag1 > mag2);
    endcase
  end

  // Select the condition requested by funct.
  always_comb begin
    // NOTE: default assignment first so every path drives taken and no latch is inferred.
    taken = 1'b0;
    unique case (funct)
      BEQ:     taken = eq;
      BNE:     taken = ~eq;
      BLT:     taken = (read1 < read2);
      BLE:     taken = (read1 <= read2);
      FBLT:    taken = flt;
      FBLE:    taken = flt | eq;
      FBPS:    taken = ~sign2;
      default: taken = sign2;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: registered outcome behind valid/ready, BHT and statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct,
  input  logic [XLEN-1:0]  in_read1,
  input  logic [XLEN-1:0]  in_read2,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_target,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic [XLEN-1:0]  out_redirect_pc,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic             cond_taken;
  logic             accept;
  logic             retire;
  logic [IDX_W-1:0] in_idx;
  logic [IDX_W-1:0] pred_idx;
  logic             unused_pred_bits;

  logic             out_valid_q,      out_valid_d;
  logic             out_taken_q,      out_taken_d;
  logic             out_mispredict_q, out_mispredict_d;
  logic [XLEN-1:0]  out_redirect_q,   out_redirect_d;
  logic [IDX_W-1:0] out_idx_q,        out_idx_d;
  logic [CNT_W-1:0] stat_branches_q,  stat_branches_d;
  logic [CNT_W-1:0] stat_mispred_q,   stat_mispred_d;
  bht_ctr_t         bht_q [BHT_DEPTH];
  bht_ctr_t         bht_d [BHT_DEPTH];

  branch_cond #(.XLEN(XLEN)) u_cond (
    .funct (funct_e'(in_funct)),
    .read1 (in_read1),
    .read2 (in_read2),
    .taken (cond_taken)
  );

  // Handshake: flush kills both the incoming branch and the retiring one.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;
  assign retire   = out_valid_q & out_ready & ~flush;

  // BHT indexing skips the two byte-offset bits of the word-aligned PC.
  assign in_idx           = in_pc[IDX_W+1:2];
  assign pred_idx         = pred_pc[IDX_W+1:2];
  assign unused_pred_bits = ^pred_pc;
  assign pred_taken       = bht_q[pred_idx][1];

  // Next-state for the output register, BHT entry and statistics.
  always_comb begin
    out_valid_d      = out_valid_q;
    out_taken_d      = out_taken_q;
    out_mispredict_d = out_mispredict_q;
    out_redirect_d   = out_redirect_q;
    out_idx_d        = out_idx_q;
    stat_branches_d  = stat_branches_q;
    stat_mispred_d   = stat_mispred_q;
    bht_d            = bht_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else begin
      if (retire) begin
        out_valid_d     = 1'b0;
        stat_branches_d = stat_branches_q + CNT_W'(1);
        stat_mispred_d  = stat_mispred_q + CNT_W'(out_mispredict_q);
        bht_d[out_idx_q] = out_taken_q ? sat_inc(bht_q[out_idx_q])
                                       : sat_dec(bht_q[out_idx_q]);
      end
      if (accept) begin
        out_valid_d      = 1'b1;
        out_taken_d      = cond_taken;
        out_mispredict_d = cond_taken ^ in_pred_taken;
        out_redirect_d   = cond_taken ? in_target : in_pc + XLEN'(PC_STEP);
        out_idx_d        = in_idx;
      end
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_mispredict_q <= 1'b0;
      out_redirect_q   <= '0;
      out_idx_q        <= '0;
      stat_branches_q  <= '0;
      stat_mispred_q   <= '0;
      // NOTE: the BHT is a flop array, so every entry is reset to weakly-not-taken here.
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= BHT_INIT;
      end
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      out_valid_q      <= out_valid_d;
      out_taken_q      <= out_taken_d;
      out_mispredict_q <= out_mispredict_d;
      out_redirect_q   <= out_redirect_d;
      out_idx_q        <= out_idx_d;
      stat_branches_q  <= stat_branches_d;
      stat_mispred_q   <= stat_mispred_d;
      bht_q            <= bht_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_taken        = out_taken_q;
  assign out_mispredict   = out_mispredict_q;
  assign out_redirect_pc  = out_redirect_q;
  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispred_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit: vector table plus hand-written sequences.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default parameters.
  logic        rstn, flush, in_valid, in_ready, in_pred_taken;
  logic [2:0]  in_funct;
  logic [31:0] in_read1, in_read2, in_pc, in_target;
  logic        out_valid, out_ready, out_taken, out_mispredict;
  logic [31:0] out_redirect_pc, pred_pc;
  logic        pred_taken;
  logic [31:0] stat_branches, stat_mispredicts;

  branch_resolve_unit dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_read1(in_read1), .in_read2(in_read2), .in_pc(in_pc),
    .in_target(in_target), .in_pred_taken(in_pred_taken), .out_valid(out_valid),
    .out_ready(out_ready), .out_taken(out_taken), .out_mispredict(out_mispredict),
    .out_redirect_pc(out_redirect_pc), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // Narrow instance: XLEN=16, CNT_W=4.
  logic        b_flush, b_in_valid, b_in_ready, b_in_pred_taken;
  logic [2:0]  b_in_funct;
  logic [15:0] b_in_read1, b_in_read2, b_in_pc, b_in_target;
  logic        b_out_valid, b_out_ready, b_out_taken, b_out_mispredict;
  logic [15:0] b_out_redirect_pc, b_pred_pc;
  logic        b_pred_taken;
  logic [3:0]  b_stat_branches, b_stat_mispredicts;

  branch_resolve_unit #(.XLEN(16), .BHT_DEPTH(64), .CNT_W(4)) dut_b (
    .clk(clk), .rstn(rstn), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_funct(b_in_funct), .in_read1(b_in_read1), .in_read2(b_in_read2), .in_pc(b_in_pc),
    .in_target(b_in_target), .in_pred_taken(b_in_pred_taken), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_taken(b_out_taken), .out_mispredict(b_out_mispredict),
    .out_redirect_pc(b_out_redirect_pc), .pred_pc(b_pred_pc), .pred_taken(b_pred_taken),
    .stat_branches(b_stat_branches), .stat_mispredicts(b_stat_mispredicts)
  );

  typedef struct {
    funct_e      funct;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        pred;
    logic        exp_taken;
    logic        exp_misp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input funct_e f, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    in_valid      = 1'b1;
    in_funct      = f;
    in_read1      = r1;
    in_read2      = r2;
    in_pc         = pc;
    in_target     = tgt;
    in_pred_taken = pred;
  endtask

  vec_t vecs [16];

  initial begin
    logic [31:0] pc;
    logic [31:0] tgt;
    int          exp_misp_cnt;

    vecs[0]  = '{BEQ,  32'd5,          32'd5,          1'b0, 1'b1, 1'b1};
    vecs[1]  = '{BEQ,  32'd5,          32'd6,          1'b0, 1'b0, 1'b0};
    vecs[2]  = '{BNE,  32'd5,          32'd6,          1'b1, 1'b1, 1'b0};
    vecs[3]  = '{BLT,  32'd1,          32'hFFFF_FFFF,  1'b0, 1'b1, 1'b1};
    vecs[4]  = '{BLT,  32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 1'b0};
    vecs[5]  = '{BLE,  32'd7,          32'd7,          1'b1, 1'b1, 1'b0};
    vecs[6]  = '{FBLT, 32'h8000_0000,  32'h0000_0000,  1'b0, 1'b1, 1'b1};
    vecs[7]  = '{FBLT, 32'hC000_0000,  32'hBF80_0000,  1'b1, 1'b1, 1'b0};
    vecs[8]  = '{FBLT, 32'h3F80_0000,  32'h4000_0000,  1'b0, 1'b1, 1'b1};
    vecs[9]  = '{FBLT, 32'h4000_0000,  32'h8000_0000,  1'b1, 1'b0, 1'b1};
    vecs[10] = '{FBLE, 32'h3F80_0000,  32'h3F80_0000,  1'b0, 1'b1, 1'b1};
    vecs[11] = '{FBLE, 32'h4000_0000,  32'h3F80_0000,  1'b0, 1'b0, 1'b0};
    vecs[12] = '{FBPS, 32'h1234_5678,  32'h0000_0001,  1'b1, 1'b1, 1'b0};
    vecs[13] = '{FBNG, 32'h1234_5678,  32'h8000_0000,  1'b0, 1'b1, 1'b1};
    vecs[14] = '{FBNG, 32'h1234_5678,  32'h7FFF_FFFF,  1'b0, 1'b0, 1'b0};
    vecs[15] = '{BNE,  32'd9,          32'd9,          1'b1, 1'b0, 1'b1};

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct = 3'd0; in_read1 = '0; in_read2 = '0; in_pc = '0; in_target = '0;
    in_pred_taken = 1'b0; pred_pc = 32'h0000_2040;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_funct = 3'd0;
    b_in_read1 = '0; b_in_read2 = '0; b_in_pc = '0; b_in_target = '0;
    b_in_pred_taken = 1'b0; b_pred_pc = '0;
    repeat (2) step();
    rstn = 1'b1;
    step();

    // Reset state.
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_taken", 64'(out_taken), 64'd0);
    check("rst_out_misp", 64'(out_mispredict), 64'd0);
    check("rst_redirect", 64'(out_redirect_pc), 64'd0);
    check("rst_stat_br", 64'(stat_branches), 64'd0);
    check("rst_stat_mp", 64'(stat_mispredicts), 64'd0);
    check("rst_pred_taken", 64'(pred_taken), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Table vectors, back-to-back at full throughput.
    exp_misp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      pc  = 32'h0000_0100 + 32'(4 * i);
      tgt = 32'h0000_4000 + 32'(16 * i);
      drive(vecs[i].funct, vecs[i].r1, vecs[i].r2, pc, tgt, vecs[i].pred);
      step();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_taken", i), 64'(out_taken), 64'(vecs[i].exp_taken));
      check($sformatf("vec%0d_misp", i), 64'(out_mispredict), 64'(vecs[i].exp_misp));
      check($sformatf("vec%0d_redir", i), 64'(out_redirect_pc),
            64'(vecs[i].exp_taken ? tgt : pc + 32'd4));
      if (vecs[i].exp_misp) exp_misp_cnt++;
    end
    in_valid = 1'b0;
    step();
    check("vec_drain_valid", 64'(out_valid), 64'd0);
    check("vec_stat_br", 64'(stat_branches), 64'd16);
    check("vec_stat_mp", 64'(stat_mispredicts), 64'd8);

    // Back-pressure: out_ready low for 3 cycles holds the result and blocks input.
    out_ready = 1'b0;
    drive(BEQ, 32'd1, 32'd1, 32'h0000_0300, 32'h0000_0500, 1'b1);
    step();
    drive(BNE, 32'd1, 32'd2, 32'h0000_0304, 32'h0000_0600, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
      check($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d_redir", c), 64'(out_redirect_pc), 64'h500);
      check($sformatf("stall%0d_misp", c), 64'(out_mispredict), 64'd0);
    end
    out_ready = 1'b1;
    step();
    check("release_valid", 64'(out_valid), 64'd1);
    check("release_redir", 64'(out_redirect_pc), 64'h600);
    check("release_misp", 64'(out_mispredict), 64'd1);
    in_valid = 1'b0;
    step();
    check("release_stat_br", 64'(stat_branches), 64'd18);
    check("release_stat_mp", 64'(stat_mispredicts), 64'd9);

    // BHT training on pc 0x2040: 01->10->11->11->11, then not-taken 11->10->01.
    for (int k = 0; k < 4; k++) begin
      drive(BEQ, 32'd0, 32'd0, 32'h0000_2040, 32'h0000_3000, 1'b0);
      step();
      in_valid = 1'b0;
      check($sformatf("bht_pre%0d", k), 64'(pred_taken), 64'(k != 0));
      step();
      check($sformatf("bht_taken%0d", k), 64'(pred_taken), 64'd1);
    end
    drive(BEQ, 32'd0, 32'd1, 32'h0000_2040, 32'h0000_3000, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    check("bht_nt1", 64'(pred_taken), 64'd1);
    drive(BEQ, 32'd0, 32'd1, 32'h0000_2040, 32'h0000_3000, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    check("bht_nt2", 64'(pred_taken), 64'd0);
    check("bht_stat_br", 64'(stat_branches), 64'd24);
    check("bht_stat_mp", 64'(stat_mispredicts), 64'd13);

    // Flush with a retiring result and a new incoming branch.
    drive(BEQ, 32'd0, 32'd0, 32'h0000_2040, 32'h0000_3000, 1'b0);
    step();
    drive(BEQ, 32'd0, 32'd0, 32'h0000_2040, 32'h0000_3000, 1'b0);
    flush = 1'b1;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_stat_br", 64'(stat_branches), 64'd24);
    check("flush_stat_mp", 64'(stat_mispredicts), 64'd13);
    check("flush_bht", 64'(pred_taken), 64'd0);
    step();
    check("flush_dropped", 64'(out_valid), 64'd0);
    check("flush_bht_later", 64'(pred_taken), 64'd0);

    // Asynchronous reset mid-operation.
    drive(BEQ, 32'd3, 32'd3, 32'h0000_2040, 32'h0000_3000, 1'b0);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("midrst_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_redir", 64'(out_redirect_pc), 64'd0);
    check("midrst_stat_br", 64'(stat_branches), 64'd0);
    check("midrst_stat_mp", 64'(stat_mispredicts), 64'd0);
    step();
    rstn = 1'b1;
    out_ready = 1'b1;
    step();

    // Narrow instance: pc+4 wraps at 2^16, stats wrap at 2^4.
    b_in_valid = 1'b1;
    b_in_funct = 3'(BNE);
    b_in_read1 = 16'd3;
    b_in_read2 = 16'd3;
    b_in_pc    = 16'hFFFC;
    b_in_target = 16'h1000;
    b_in_pred_taken = 1'b0;
    step();
    check("x16_taken", 64'(b_out_taken), 64'd0);
    check("x16_redir_wrap", 64'(b_out_redirect_pc), 64'h0000);
    for (int n = 1; n < 17; n++) begin
      b_in_pc = 16'(16'h0100 + 16'(4 * n));
      step();
    end
    b_in_valid = 1'b0;
    step();
    check("cnt4_valid", 64'(b_out_valid), 64'd0);
    check("cnt4_wrap", 64'(b_stat_branches), 64'd1);
    check("cnt4_mp", 64'(b_stat_mispredicts), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
